manual_step_gen: RTL and testbench

- Source side of the manual-clock interface: turns a raw, bouncing push-button into clean, fixed-width single-step clock pulses on manual_clk.
- Its output feeds the clock selector's manual input, which selects it in CLK_MANUAL mode.
- Supports a burst mode: one press emits 1..15 step pulses.
- Keeps a running step counter for the seven-segment/debug display.

---
 rtl/manual_step_gen_pkg.sv | 33 +++
 rtl/manual_step_gen_btn_debounce.sv | 65 ++++++
 rtl/manual_step_gen.sv | 136 +++++++++++++
 tb/tb_manual_step_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/manual_step_gen_pkg.sv
// ----------------------------------------------------------------------------
// manual_step_gen_pkg
// Shared definitions for the manual single-step clock path:
//   - step generator FSM state encoding
//   - default debounce / half-period constants
//   - clock-mode encodings shared with the clock selector
//   - burst_count(): maps a raw burst_len to the number of pulses to emit
// ----------------------------------------------------------------------------
package manual_step_gen_pkg;

    localparam int unsigned DEF_DEBOUNCE_MAX = 1000000;
    localparam int unsigned DEF_HALF_PERIOD  = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HIGH         = 2'd1,
        ST_LOW          = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } step_state_e;

    typedef enum logic [1:0] {
        CLK_MANUAL = 2'd0,
        CLK_SLOW   = 2'd1,
        CLK_FAST   = 2'd2,
        CLK_EX     = 2'd3
    } clk_mode_e;

    // A burst length of zero still produces one pulse.
    function automatic logic [3:0] burst_count(input logic [3:0] len);
        return (len == 4'd0) ? 4'd1 : len;
    endfunction

endpackage

// File: rtl/manual_step_gen_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser plus counter-based debouncer for a raw push-button.
// Ports:
//   clk_in1  in   clock (rising edge)
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   raw, asynchronous, bouncing button (active-high)
//   level    out  debounced button level
//   press    out  one-cycle pulse following a debounced 0->1 transition
// ----------------------------------------------------------------------------
module btn_debounce
    import manual_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MAX = DEF_DEBOUNCE_MAX
) (
    input  logic clk_in1,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_MAX - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_press;
    logic [23:0] r_cnt;
    logic        w_differ;
    logic        w_flip;

    assign w_differ = (r_sync2 != r_level);
    // Flip on the cycle the counter would reach DEBOUNCE_MAX.
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            // Any cycle of agreement clears the count, rejecting short glitches.
            if (!w_differ || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 24'd1;
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
            // Registered with the flip so press is high in the cycle the new
            // level is first visible.
            r_press <= w_flip && !r_level;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/manual_step_gen.sv
// ----------------------------------------------------------------------------
// manual_step_gen
// Turns a bouncing push-button into clean single-step clock pulses, with an
// optional burst of 1..15 pulses per press and a running step counter.
// Ports:
//   clk_in1     in   clock (rising edge)
//   rst_n       in   asynchronous active-low reset
//   btn_raw     in   raw push-button (async, active-high, bouncing)
//   burst_len   in   [3:0] pulses per press, sampled at the press; 0 -> 1
//   manual_clk  out  registered step clock
//   busy        out  high while a burst is in progress
//   step_count  out  [CNT_W-1:0] total pulses emitted, wrapping
// ----------------------------------------------------------------------------
module manual_step_gen
    import manual_step_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MAX = DEF_DEBOUNCE_MAX,
    parameter int unsigned HALF_PERIOD  = DEF_HALF_PERIOD,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_in1,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic [3:0]       burst_len,
    output logic             manual_clk,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned     PH_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(HALF_PERIOD - 1);

    logic w_level;
    logic w_press;

    btn_debounce #(
        .DEBOUNCE_MAX(DEBOUNCE_MAX)
    ) u_btn_debounce (
        .clk_in1(clk_in1),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .level  (w_level),
        .press  (w_press)
    );

    step_state_e      r_state;
    logic [3:0]       r_rem;
    logic [PH_W-1:0]  r_phase;
    logic             r_manual_clk;
    logic             r_busy;
    logic [CNT_W-1:0] r_step_count;

    step_state_e      w_state_nxt;
    logic [3:0]       w_rem_nxt;
    logic [PH_W-1:0]  w_phase_nxt;
    logic             w_manual_clk_nxt;
    logic [CNT_W-1:0] w_step_count_nxt;

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rem        <= '0;
            r_phase      <= '0;
            r_manual_clk <= 1'b0;
            r_busy       <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem_nxt;
            r_phase      <= w_phase_nxt;
            r_manual_clk <= w_manual_clk_nxt;
            r_busy       <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW);
            r_step_count <= w_step_count_nxt;
        end
    end

    // The phase counter is loaded with HALF_PERIOD-1 on entry to HIGH/LOW and
    // the state advances when it reaches zero, giving exactly HALF_PERIOD
    // cycles per phase.
    always_comb begin
        w_state_nxt      = r_state;
        w_rem_nxt        = r_rem;
        w_phase_nxt      = r_phase;
        w_manual_clk_nxt = r_manual_clk;
        w_step_count_nxt = r_step_count;

        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt      = ST_HIGH;
                    w_rem_nxt        = burst_count(burst_len);
                    w_phase_nxt      = PH_LOAD;
                    w_manual_clk_nxt = 1'b1;
                    w_step_count_nxt = r_step_count + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (r_phase == '0) begin
                    w_state_nxt      = ST_LOW;
                    w_phase_nxt      = PH_LOAD;
                    w_manual_clk_nxt = 1'b0;
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            ST_LOW: begin
                if (r_phase == '0) begin
                    w_rem_nxt = r_rem - 4'd1;
                    if (r_rem > 4'd1) begin
                        w_state_nxt      = ST_HIGH;
                        w_phase_nxt      = PH_LOAD;
                        w_manual_clk_nxt = 1'b1;
                        w_step_count_nxt = r_step_count + CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_WAIT_RELEASE;
                    end
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            ST_WAIT_RELEASE: begin
                if (!w_level) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign manual_clk = r_manual_clk;
    assign busy       = r_busy;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_manual_step_gen.sv
module tb_manual_step_gen;
    import manual_step_gen_pkg::*;

    logic        clk_in1 = 1'b0;
    logic        rst_n;
    logic        btn_raw;
    logic [3:0]  burst_len;
    logic        manual_clk;
    logic        busy;
    logic [15:0] step_count;

    manual_step_gen #(
        .DEBOUNCE_MAX(4),
        .HALF_PERIOD (2),
        .CNT_W       (16)
    ) dut (
        .clk_in1   (clk_in1),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .burst_len (burst_len),
        .manual_clk(manual_clk),
        .busy      (busy),
        .step_count(step_count)
    );

    always #5 clk_in1 = ~clk_in1;

    int cyc = 0;
    always @(posedge clk_in1) cyc <= cyc + 1;

    typedef struct {
        int          rise;
        int          hi;
        logic [15:0] step;
    } pulse_t;

    pulse_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int rise, input int step);
        pulse_t p;
        p.rise = rise;
        p.hi   = 2;
        p.step = 16'(step);
        exp_q.push_back(p);
    endtask

    // Monitor: each completed manual_clk pulse is matched against the queue.
    bit          in_pulse = 0;
    int          rise_c;
    logic [15:0] rise_step;
    always @(negedge clk_in1) begin
        if (!rst_n) begin
            in_pulse = 0;
        end else if (!in_pulse && manual_clk) begin
            in_pulse  = 1;
            rise_c    = cyc;
            rise_step = step_count;
        end else if (in_pulse && !manual_clk) begin
            pulse_t p;
            in_pulse = 0;
            check("pulse_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                check("pulse_rise_cycle", rise_c, p.rise);
                check("pulse_high_width", cyc - rise_c, p.hi);
                check("pulse_step_count", rise_step, p.step);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in1);
    endtask

    task automatic do_reset();
        @(negedge clk_in1);
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic end_test(input string name);
        check({name, "_missing_pulses"}, exp_q.size(), 0);
        exp_q.delete();
        do_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;

        rst_n     = 1'b0;
        btn_raw   = 1'b0;
        burst_len = 4'd0;
        tick(2);
        check("rst_manual_clk", manual_clk, 0);
        check("rst_busy", busy, 0);
        check("rst_step_count", step_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press, burst_len 0 -> one pulse
        burst_len = 4'd0;
        k = cyc;
        btn_raw = 1'b1;
        push(k + 7, 1);
        tick(6);
        check("clean_busy_before", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("clean_busy_during", busy, 1);
        end
        tick(1);
        check("clean_busy_after", busy, 0);
        tick(9);
        btn_raw = 1'b0;
        tick(12);
        check("clean_step_count", step_count, 1);
        end_test("clean");

        // Bounce: toggle every 2 cycles for 30 cycles, ending high
        k = cyc;
        for (int i = 0; i < 15; i++) begin
            btn_raw = ~btn_raw;
            k = cyc;
            tick(2);
        end
        push(k + 7, 1);
        tick(20);
        btn_raw = 1'b0;
        tick(12);
        check("bounce_step_count", step_count, 1);
        end_test("bounce");

        // Burst of 3, with a second press landing in LOW and burst_len changed
        burst_len = 4'd3;
        k = cyc;
        btn_raw = 1'b1;
        push(k + 7, 1);
        push(k + 11, 2);
        push(k + 15, 3);
        tick(7);
        burst_len = 4'd9;
        btn_raw   = 1'b0;
        tick(4);
        btn_raw = 1'b1;
        tick(15);
        check("burst_step_count_held", step_count, 3);
        check("burst_busy_held", busy, 0);
        check("burst_state_held", dut.r_state, ST_WAIT_RELEASE);
        burst_len = 4'd2;
        btn_raw   = 1'b0;
        tick(12);
        k = cyc;
        btn_raw = 1'b1;
        push(k + 7, 4);
        push(k + 11, 5);
        tick(20);
        btn_raw = 1'b0;
        tick(12);
        check("burst_step_count_final", step_count, 5);
        end_test("burst");

        // Wrap: preload counter to all-ones
        force dut.r_step_count = 16'hFFFF;
        tick(1);
        release dut.r_step_count;
        tick(1);
        check("wrap_preload", step_count, 16'hFFFF);
        burst_len = 4'd0;
        k = cyc;
        btn_raw = 1'b1;
        push(k + 7, 0);
        tick(20);
        btn_raw = 1'b0;
        tick(12);
        check("wrap_step_count", step_count, 0);
        end_test("wrap");

        // Reset during the second pulse of a 5-burst
        burst_len = 4'd5;
        k = cyc;
        btn_raw = 1'b1;
        push(k + 7, 1);
        tick(12);
        check("rstmid_pre_mclk", manual_clk, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_manual_clk", manual_clk, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_step_count", step_count, 0);
        check("rstmid_q_first", exp_q.size(), 0);
        tick(2);
        r = cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) push(r + 7 + 4 * i, i + 1);
        tick(30);
        btn_raw = 1'b0;
        tick(12);
        check("rstmid_step_count_final", step_count, 5);
        end_test("rstmid");

        // Release after the first pulse of a 4-burst
        burst_len = 4'd4;
        k = cyc;
        btn_raw = 1'b1;
        for (int i = 0; i < 4; i++) push(k + 7 + 4 * i, i + 1);
        tick(9);
        btn_raw = 1'b0;
        tick(14);
        check("relmid_state_wait", dut.r_state, ST_WAIT_RELEASE);
        check("relmid_busy", busy, 0);
        tick(1);
        check("relmid_state_idle", dut.r_state, ST_IDLE);
        tick(6);
        check("relmid_step_count", step_count, 4);
        end_test("relmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
